dii_pkt_buffer: RTL and testbench



---
 rtl/dii_package.sv | 11 +
 rtl/dii_buffer_mem.sv | 27 ++
 rtl/dii_pkt_buffer.sv | 121 ++++++++++++
 tb/tb_dii_pkt_buffer.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dii_package.sv
// rtl/dii_package.sv - DII flit type shared by the debug interconnect
package dii_package;

  // One ring flit: handshake valid, end-of-packet marker and 16-bit payload
  typedef struct packed {
    logic        valid;
    logic        last;
    logic [15:0] data;
  } dii_flit;

endpackage

// File: rtl/dii_buffer_mem.sv
// rtl/dii_buffer_mem.sv - flit storage array, synchronous write and asynchronous read
module dii_buffer_mem #(
  parameter int  DEPTH = 16,
  parameter int  WIDTH = 17,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Store the incoming word at the write address on each enabled edge
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Head entry is presented combinationally so the output flit follows rd_ptr
  assign rdata = mem[raddr];

endmodule

// File: rtl/dii_pkt_buffer.sv
// rtl/dii_pkt_buffer.sv - packet-aware DII flit FIFO for the ring output legs
module dii_pkt_buffer
  import dii_package::*;
#(
  parameter int DEPTH       = 16,
  parameter bit FULL_PACKET = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  dii_flit                 flit_in,
  output logic                    flit_in_ready,
  output dii_flit                 flit_out,
  input  logic                    flit_out_ready,
  output logic [$clog2(DEPTH):0]  packet_count,
  output logic [$clog2(DEPTH):0]  fill_level
);

  // Stored word is the flit without its valid bit: {last, data}
  localparam int DII_FLIT_WIDTH = $bits(dii_flit) - 1;
  localparam int PTR_W          = $clog2(DEPTH);
  localparam int CNT_W          = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_LEVEL = CNT_W'(DEPTH);

  logic [PTR_W-1:0]          wr_ptr;
  logic [PTR_W-1:0]          rd_ptr;
  logic                      draining;
  logic                      is_full;
  logic                      is_empty;
  logic                      out_valid;
  logic                      wr_en;
  logic                      rd_en;
  logic                      wr_last;
  logic                      rd_last;
  logic [DII_FLIT_WIDTH-1:0] wr_word;
  logic [DII_FLIT_WIDTH-1:0] rd_word;

  assign is_full  = (fill_level == FULL_LEVEL);
  assign is_empty = (fill_level == '0);

  // Full blocks writes even when a read frees a slot in the same cycle
  assign flit_in_ready = !is_full;

  // Store-and-forward waits for a whole packet; a full buffer with no complete
  // packet (oversized packet) falls back to cut-through until its last flit leaves
  assign out_valid = !is_empty &&
                     (!FULL_PACKET || (packet_count != '0) || is_full || draining);

  assign wr_en   = flit_in.valid && flit_in_ready;
  assign rd_en   = out_valid && flit_out_ready;
  assign wr_word = {flit_in.last, flit_in.data};
  assign wr_last = wr_en && flit_in.last;
  assign rd_last = rd_en && rd_word[DII_FLIT_WIDTH-1];

  assign flit_out = {out_valid, rd_word};

  dii_buffer_mem #(
    .DEPTH (DEPTH),
    .WIDTH (DII_FLIT_WIDTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (wr_word),
    .raddr (rd_ptr),
    .rdata (rd_word)
  );

  // Circular pointers advance on their own handshake and wrap modulo DEPTH
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Flit occupancy: simultaneous read and write leaves the level unchanged
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fill_level <= '0;
    end else begin
      case ({wr_en, rd_en})
        2'b10:   fill_level <= fill_level + 1'b1;
        2'b01:   fill_level <= fill_level - 1'b1;
        default: fill_level <= fill_level;
      endcase
    end
  end

  // Complete-packet count tracks last flits entering and leaving
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      packet_count <= '0;
    end else begin
      case ({wr_last, rd_last})
        2'b10:   packet_count <= packet_count + 1'b1;
        2'b01:   packet_count <= packet_count - 1'b1;
        default: packet_count <= packet_count;
      endcase
    end
  end

  // Oversized-packet escape: armed when full with no complete packet, released
  // when that packet's last flit is read out
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      draining <= 1'b0;
    end else if (rd_last) begin
      draining <= 1'b0;
    end else if (is_full && (packet_count == '0)) begin
      draining <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dii_pkt_buffer.sv
// tb/tb_dii_pkt_buffer.sv - randomized model-checked bench for dii_pkt_buffer
module tb_dii_pkt_buffer;
  import dii_package::*;

  logic clk = 1'b0;
  logic rst_n;

  // Driven stimulus, routed to the instance selected by sel
  dii_flit drv_in;
  logic    drv_rdy;
  int      sel;

  dii_flit in_sf, in_ct, in_sm;
  dii_flit out_sf, out_ct, out_sm;
  logic    ordy_sf, ordy_ct, ordy_sm;
  logic    irdy_sf, irdy_ct, irdy_sm;
  logic [4:0] pc_sf, pc_ct, fl_sf, fl_ct;
  logic [2:0] pc_sm, fl_sm;

  dii_flit    cur_out;
  logic       cur_in_rdy;
  logic [4:0] cur_pcnt, cur_flvl;

  int checks = 0;
  int errors = 0;

  // Behavioural model: ordered queue of stored {last,data} words plus drain flag
  logic [16:0] mq [$];
  int          m_depth;
  bit          m_fp;
  bit          m_drain;

  always #5 clk = ~clk;

  dii_pkt_buffer #(.DEPTH(16), .FULL_PACKET(1'b1)) u_sf (
    .clk(clk), .rst(rst_n), .flit_in(in_sf), .flit_in_ready(irdy_sf),
    .flit_out(out_sf), .flit_out_ready(ordy_sf), .packet_count(pc_sf), .fill_level(fl_sf)
  );

  dii_pkt_buffer #(.DEPTH(16), .FULL_PACKET(1'b0)) u_ct (
    .clk(clk), .rst(rst_n), .flit_in(in_ct), .flit_in_ready(irdy_ct),
    .flit_out(out_ct), .flit_out_ready(ordy_ct), .packet_count(pc_ct), .fill_level(fl_ct)
  );

  dii_pkt_buffer #(.DEPTH(4), .FULL_PACKET(1'b1)) u_sm (
    .clk(clk), .rst(rst_n), .flit_in(in_sm), .flit_in_ready(irdy_sm),
    .flit_out(out_sm), .flit_out_ready(ordy_sm), .packet_count(pc_sm), .fill_level(fl_sm)
  );

  always_comb begin
    in_sf = '0; in_ct = '0; in_sm = '0;
    ordy_sf = 1'b0; ordy_ct = 1'b0; ordy_sm = 1'b0;
    case (sel)
      1:       begin in_ct = drv_in; ordy_ct = drv_rdy; end
      2:       begin in_sm = drv_in; ordy_sm = drv_rdy; end
      default: begin in_sf = drv_in; ordy_sf = drv_rdy; end
    endcase
  end

  always_comb begin
    case (sel)
      1: begin
        cur_out = out_ct; cur_in_rdy = irdy_ct; cur_pcnt = pc_ct; cur_flvl = fl_ct;
      end
      2: begin
        cur_out = out_sm; cur_in_rdy = irdy_sm;
        cur_pcnt = {2'b00, pc_sm}; cur_flvl = {2'b00, fl_sm};
      end
      default: begin
        cur_out = out_sf; cur_in_rdy = irdy_sf; cur_pcnt = pc_sf; cur_flvl = fl_sf;
      end
    endcase
  end

  function automatic int model_packets();
    int n = 0;
    foreach (mq[i]) if (mq[i][16]) n++;
    return n;
  endfunction

  function automatic bit model_valid();
    if (mq.size() == 0) return 1'b0;
    if (!m_fp) return 1'b1;
    return (model_packets() != 0) || (mq.size() == m_depth) || m_drain;
  endfunction

  // Check outputs at the negedge, then advance one clock and update the model
  task automatic cycle();
    bit          ev, wr, rd, set_drain;
    logic [16:0] head;
    ev = model_valid();
    checks++;
    if (cur_out.valid !== ev) begin
      errors++;
      $display("FAIL out_valid t=%0t sel=%0d got %b expected %b", $time, sel, cur_out.valid, ev);
    end
    if (ev) begin
      head = mq[0];
      checks++;
      if ({cur_out.last, cur_out.data} !== head) begin
        errors++;
        $display("FAIL out_flit t=%0t sel=%0d got last=%b data=%h expected last=%b data=%h",
                 $time, sel, cur_out.last, cur_out.data, head[16], head[15:0]);
      end
    end
    checks++;
    if (cur_in_rdy !== (mq.size() != m_depth)) begin
      errors++;
      $display("FAIL in_ready t=%0t sel=%0d got %b expected %b", $time, sel, cur_in_rdy, mq.size() != m_depth);
    end
    checks++;
    if (cur_flvl !== 5'(mq.size())) begin
      errors++;
      $display("FAIL fill_level t=%0t sel=%0d got %0d expected %0d", $time, sel, cur_flvl, mq.size());
    end
    checks++;
    if (cur_pcnt !== 5'(model_packets())) begin
      errors++;
      $display("FAIL packet_count t=%0t sel=%0d got %0d expected %0d", $time, sel, cur_pcnt, model_packets());
    end
    wr        = drv_in.valid && (mq.size() != m_depth);
    rd        = ev && drv_rdy;
    set_drain = (mq.size() == m_depth) && (model_packets() == 0);
    @(posedge clk);
    head = '0;
    if (rd) head = mq.pop_front();
    if (rd && head[16]) m_drain = 1'b0;
    else if (set_drain) m_drain = 1'b1;
    if (wr) mq.push_back({drv_in.last, drv_in.data});
    @(negedge clk);
  endtask

  // Hold one flit valid until accepted, with a bounded wait
  task automatic send_flit(input bit l, input logic [15:0] d);
    bit acc;
    int n;
    drv_in = '{valid: 1'b1, last: l, data: d};
    acc = 1'b0;
    n = 0;
    while (!acc && n < 50) begin
      acc = cur_in_rdy;
      cycle();
      n++;
    end
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL send_timeout sel=%0d data=%h not accepted after %0d cycles (required accept)", sel, d, n);
    end
    drv_in.valid = 1'b0;
  endtask

  task automatic idle(input int n);
    drv_in = '0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset(input int s, input int depth, input bit fp);
    sel     = s;
    m_depth = depth;
    m_fp    = fp;
    drv_in  = '0;
    drv_rdy = 1'b0;
    rst_n   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    mq.delete();
    m_drain = 1'b0;
    rst_n   = 1'b1;
  endtask

  task automatic test_reset();
    drv_in  = '0;
    drv_rdy = 1'b0;
    rst_n   = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      sel = k;
      #1;
      checks++;
      if (cur_out.valid !== 1'b0 || cur_in_rdy !== 1'b1 || cur_flvl !== 5'd0 || cur_pcnt !== 5'd0) begin
        errors++;
        $display("FAIL reset_state sel=%0d got valid=%b in_ready=%b fill=%0d pkts=%0d expected 0 1 0 0",
                 k, cur_out.valid, cur_in_rdy, cur_flvl, cur_pcnt);
      end
    end
  endtask

  task automatic test_store_forward();
    do_reset(0, 16, 1'b1);
    drv_rdy = 1'b1;
    send_flit(1'b0, 16'h0001);
    send_flit(1'b0, 16'h0002);
    checks++;
    if (cur_out.valid !== 1'b0) begin
      errors++;
      $display("FAIL sf_hold got valid=%b expected 0 before last flit", cur_out.valid);
    end
    send_flit(1'b1, 16'h0003);
    checks++;
    if (cur_out.valid !== 1'b1 || cur_out.data !== 16'h0001 || cur_pcnt !== 5'd1) begin
      errors++;
      $display("FAIL sf_release got valid=%b data=%h pkts=%0d expected 1 0001 1",
               cur_out.valid, cur_out.data, cur_pcnt);
    end
    idle(6);
  endtask

  task automatic test_cut_through();
    do_reset(1, 16, 1'b0);
    drv_rdy = 1'b1;
    send_flit(1'b0, 16'h0001);
    checks++;
    if (cur_out.valid !== 1'b1 || cur_out.data !== 16'h0001) begin
      errors++;
      $display("FAIL ct_latency got valid=%b data=%h expected 1 0001", cur_out.valid, cur_out.data);
    end
    send_flit(1'b0, 16'h0002);
    send_flit(1'b1, 16'h0003);
    idle(4);
  endtask

  task automatic test_full();
    do_reset(0, 16, 1'b1);
    for (int i = 0; i < 16; i++) send_flit(1'b1, 16'h0100 + 16'(i));
    checks++;
    if (cur_flvl !== 5'd16 || cur_pcnt !== 5'd16 || cur_in_rdy !== 1'b0) begin
      errors++;
      $display("FAIL full_state got fill=%0d pkts=%0d in_ready=%b expected 16 16 0",
               cur_flvl, cur_pcnt, cur_in_rdy);
    end
    drv_in = '{valid: 1'b1, last: 1'b1, data: 16'h0bad};
    cycle();
    cycle();
    drv_rdy = 1'b1;
    cycle();
    drv_rdy = 1'b0;
    checks++;
    if (cur_in_rdy !== 1'b1 || cur_flvl !== 5'd15) begin
      errors++;
      $display("FAIL full_free got in_ready=%b fill=%0d expected 1 15", cur_in_rdy, cur_flvl);
    end
    cycle();
    checks++;
    if (cur_flvl !== 5'd16) begin
      errors++;
      $display("FAIL full_accept17 got fill=%0d expected 16", cur_flvl);
    end
    drv_rdy = 1'b1;
    idle(20);
  endtask

  task automatic test_oversized();
    do_reset(2, 4, 1'b1);
    drv_rdy = 1'b1;
    for (int i = 1; i <= 6; i++) send_flit(i == 6, 16'h0200 + 16'(i));
    idle(8);
    checks++;
    if (cur_pcnt !== 5'd0 || cur_flvl !== 5'd0) begin
      errors++;
      $display("FAIL oversize_end got pkts=%0d fill=%0d expected 0 0", cur_pcnt, cur_flvl);
    end
    send_flit(1'b0, 16'h0a01);
    send_flit(1'b0, 16'h0a02);
    idle(3);
    checks++;
    if (cur_out.valid !== 1'b0) begin
      errors++;
      $display("FAIL oversize_drain_clear got valid=%b expected 0 for partial packet", cur_out.valid);
    end
  endtask

  task automatic test_back_to_back();
    do_reset(0, 16, 1'b1);
    send_flit(1'b1, 16'h0300);
    send_flit(1'b1, 16'h0301);
    drv_rdy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drv_in = '{valid: 1'b1, last: 1'b1, data: 16'h0310 + 16'(i)};
      checks++;
      if (cur_flvl !== 5'd2) begin
        errors++;
        $display("FAIL stream_level cycle=%0d got fill=%0d expected 2", i, cur_flvl);
      end
      cycle();
    end
    idle(6);
  endtask

  task automatic test_reset_mid();
    do_reset(1, 16, 1'b0);
    for (int i = 0; i < 5; i++) send_flit(1'b0, 16'h0400 + 16'(i));
    drv_in = '0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (cur_out.valid !== 1'b0 || cur_flvl !== 5'd0 || cur_pcnt !== 5'd0) begin
      errors++;
      $display("FAIL async_reset got valid=%b fill=%0d pkts=%0d expected 0 0 0",
               cur_out.valid, cur_flvl, cur_pcnt);
    end
    mq.delete();
    m_drain = 1'b0;
    @(negedge clk);
    rst_n   = 1'b1;
    drv_rdy = 1'b1;
    send_flit(1'b0, 16'h0501);
    send_flit(1'b0, 16'h0502);
    send_flit(1'b1, 16'h0503);
    idle(4);
  endtask

  task automatic test_random(input int s, input int depth, input bit fp, input int n);
    bit acc;
    do_reset(s, depth, fp);
    for (int c = 0; c < n; c++) begin
      if (!drv_in.valid && ($urandom_range(0, 3) != 0)) begin
        drv_in.valid = 1'b1;
        drv_in.last  = (depth == 4) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) == 0);
        drv_in.data  = 16'($urandom);
      end
      drv_rdy = ($urandom_range(0, 3) != 0);
      acc = drv_in.valid && cur_in_rdy;
      cycle();
      if (acc) drv_in.valid = 1'b0;
    end
    drv_rdy = 1'b1;
    idle(40);
  endtask

  initial begin
    sel     = 0;
    m_depth = 16;
    m_fp    = 1'b1;
    m_drain = 1'b0;
    drv_in  = '0;
    drv_rdy = 1'b0;
    rst_n   = 1'b0;
    test_reset();
    test_store_forward();
    test_cut_through();
    test_full();
    test_oversized();
    test_back_to_back();
    test_reset_mid();
    test_random(0, 16, 1'b1, 400);
    test_random(1, 16, 1'b0, 400);
    test_random(2, 4, 1'b1, 400);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
